// File: rtl/jpeg_mem_pkg.sv
// Shared widths and FSM state type for the JPEG pixel-memory arbiter.
package jpeg_mem_pkg;

   localparam int ADDR_W = 15;
   localparam int DATA_W = 64;
   localparam int RA_W   = 11;
   localparam int CA_W   = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_e;

endpackage

// File: rtl/jpeg_mem_arbiter.sv
// Two-port SRAM arbiter with burst locking and a fixed two-cycle read return.
// Define MEM_ARB_RR_EN for round-robin tie breaking in IDLE (default: port 0 wins ties).
module jpeg_mem_arbiter
   import jpeg_mem_pkg::arb_state_e, jpeg_mem_pkg::IDLE, jpeg_mem_pkg::OWN0,
          jpeg_mem_pkg::OWN1, jpeg_mem_pkg::RA_W, jpeg_mem_pkg::CA_W;
#(
   parameter int ADDR_W    = jpeg_mem_pkg::ADDR_W,
   parameter int DATA_W    = jpeg_mem_pkg::DATA_W,
   parameter int BURST_MAX = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic              lock0,
   input  logic              lock1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_nce,
   output logic              mem_nwrt,
   output logic [RA_W-1:0]   mem_ra,
   output logic [CA_W-1:0]   mem_ca,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_do
);

   localparam int CNT_W = $clog2(BURST_MAX + 1);

   arb_state_e        state_q, state_nxt;
   logic [CNT_W-1:0]  cnt_q;
   logic              prio_vld_q, prio_port_q;
   logic              tie_pick1;
   logic              acc0, acc1, acc;
   logic              burst_last;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              vld_p0, port_p0, vld_p1, port_p1;

   assign acc0       = req0 & gnt0;
   assign acc1       = req1 & gnt1;
   assign acc        = acc0 | acc1;
   assign burst_last = (int'(cnt_q) + 1) >= BURST_MAX;

   // Exit priority from a burst overrides the normal tie rule for one decision
`ifdef MEM_ARB_RR_EN
   logic rr_pref_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_pref_q <= 1'b0;
      end else if (acc) begin
         rr_pref_q <= acc0;
      end
   end

   assign tie_pick1 = prio_vld_q ? prio_port_q : rr_pref_q;
`else
   assign tie_pick1 = prio_vld_q & prio_port_q;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state_q;
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req0 && req1) begin
               gnt0 = ~tie_pick1;
               gnt1 = tie_pick1;
            end else begin
               gnt0 = req0;
               gnt1 = req1;
            end
            if (gnt0 && lock0 && (BURST_MAX > 1)) begin
               state_nxt = OWN0;
            end else if (gnt1 && lock1 && (BURST_MAX > 1)) begin
               state_nxt = OWN1;
            end
         end
         OWN0: begin
            gnt0 = req0;
            if (!req0 || !lock0 || burst_last) begin
               state_nxt = IDLE;
            end
         end
         OWN1: begin
            gnt1 = req1;
            if (!req1 || !lock1 || burst_last) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (!reset) begin
         gnt0 = 1'b0;
         gnt1 = 1'b0;
      end
   end

   // Counter holds accepted beats of the current burst, including the entry beat
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q       <= '0;
         prio_vld_q  <= 1'b0;
         prio_port_q <= 1'b0;
      end else begin
         if (state_nxt == IDLE) begin
            cnt_q <= '0;
         end else if (acc && (int'(cnt_q) < BURST_MAX)) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
         if ((state_q != IDLE) && (state_nxt == IDLE)) begin
            prio_vld_q  <= 1'b1;
            prio_port_q <= (state_q == OWN0);
         end else if ((state_q == IDLE) && acc) begin
            prio_vld_q  <= 1'b0;
         end
      end
   end

   assign sel_we    = acc1 ? we1    : we0;
   assign sel_addr  = acc1 ? addr1  : addr0;
   assign sel_wdata = acc1 ? wdata1 : wdata0;

   // p0: command issued to SRAM
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_nce  <= 1'b1;
         mem_nwrt <= 1'b1;
         mem_ra   <= '0;
         mem_ca   <= '0;
         mem_din  <= '0;
         vld_p0   <= 1'b0;
         port_p0  <= 1'b0;
      end else begin
         vld_p0  <= acc & ~sel_we;
         port_p0 <= acc1;
         if (acc) begin
            mem_nce  <= 1'b0;
            mem_nwrt <= ~sel_we;
            mem_ra   <= sel_addr[CA_W +: RA_W];
            mem_ca   <= sel_addr[CA_W-1:0];
            mem_din  <= sel_wdata;
         end else begin
            mem_nce  <= 1'b1;
            mem_nwrt <= 1'b1;
         end
      end
   end

   // p1: SRAM access cycle; p2: read data captured and returned
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_p1  <= 1'b0;
         port_p1 <= 1'b0;
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
         rdata   <= '0;
      end else begin
         vld_p1  <= vld_p0;
         port_p1 <= port_p0;
         rvalid0 <= vld_p1 & ~port_p1;
         rvalid1 <= vld_p1 & port_p1;
         if (vld_p1) begin
            rdata <= mem_do;
         end
      end
   end

endmodule

// File: tb/tb_jpeg_mem_arbiter.sv
// Directed bench for jpeg_mem_arbiter with a synchronous SRAM model and a read-return scoreboard.
module tb_jpeg_mem_arbiter;

   localparam int AW = 15;
   localparam int DW = 64;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          req0 = 1'b0, req1 = 1'b0;
   logic          we0 = 1'b0, we1 = 1'b0;
   logic          lock0 = 1'b0, lock1 = 1'b0;
   logic [AW-1:0] addr0 = '0, addr1 = '0;
   logic [DW-1:0] wdata0 = '0, wdata1 = '0;
   logic          gnt0, gnt1, rvalid0, rvalid1;
   logic [DW-1:0] rdata;
   logic          mem_nce, mem_nwrt;
   logic [10:0]   mem_ra;
   logic [3:0]    mem_ca;
   logic [DW-1:0] mem_din;
   logic [DW-1:0] mem_do = '0;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   typedef struct {
      logic          port;
      logic [DW-1:0] data;
      int            cyc;
   } exp_t;

   exp_t exp_q[$];
   exp_t got;

   jpeg_mem_arbiter dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .lock0(lock0), .lock1(lock1), .addr0(addr0), .addr1(addr1),
      .wdata0(wdata0), .wdata1(wdata1), .gnt0(gnt0), .gnt1(gnt1),
      .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
      .mem_nce(mem_nce), .mem_nwrt(mem_nwrt), .mem_ra(mem_ra), .mem_ca(mem_ca),
      .mem_din(mem_din), .mem_do(mem_do)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Synchronous SRAM: unwritten words return a fixed pattern
   logic [DW-1:0] sram [0:32767];
   bit            written [0:32767];

   function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
      if (a == 15'h1234) return 64'hA5;
      if (a == 15'h0040) return 64'h77;
      return {49'b0, a};
   endfunction

   always @(posedge clk) begin
      if (!mem_nce) begin
         if (!mem_nwrt) begin
            sram[{mem_ra, mem_ca}]    <= mem_din;
            written[{mem_ra, mem_ca}] <= 1'b1;
         end else begin
            mem_do <= written[{mem_ra, mem_ca}] ? sram[{mem_ra, mem_ca}] : init_word({mem_ra, mem_ca});
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic port, input logic [DW-1:0] data);
      exp_t e;
      e.port = port;
      e.data = data;
      e.cyc  = cyc + 1;
      exp_q.push_back(e);
   endtask

   task automatic pulse_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   // Read-return monitor
   always @(negedge clk) begin
      if (reset && (rvalid0 || rvalid1)) begin
         checks++;
         if (rvalid0 && rvalid1) begin
            failures++;
            $display("FAIL rvalid_onehot: rvalid0=1 rvalid1=1 expected at most one");
         end else if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL rvalid_unexpected: port %0d rdata %h expected no return", rvalid1, rdata);
         end else begin
            got = exp_q.pop_front();
            if (got.port !== rvalid1 || got.data !== rdata || got.cyc + 2 != cyc) begin
               failures++;
               $display("FAIL rvalid_return: port %0d rdata %h cycle %0d expected port %0d rdata %h cycle %0d",
                        rvalid1, rdata, cyc, got.port, got.data, got.cyc + 2);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state, with a pending request that must not be granted
      req0 = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check("rst_gnt0", gnt0, 0);
      check("rst_gnt1", gnt1, 0);
      check("rst_rvalid", {rvalid1, rvalid0}, 0);
      check("rst_nce_nwrt", {mem_nce, mem_nwrt}, 2'b11);
      check("rst_ra_ca", {mem_ra, mem_ca}, 0);
      @(negedge clk);
      req0 = 1'b0;
      reset = 1'b1;
      @(negedge clk);

      // Single read of 0x1234
      req0 = 1'b1; we0 = 1'b0; addr0 = 15'h1234;
      #1;
      check("rd_gnt0", gnt0, 1);
      check("rd_gnt1", gnt1, 0);
      push_exp(1'b0, 64'hA5);
      @(negedge clk);
      req0 = 1'b0;
      #1;
      check("rd_nce", mem_nce, 0);
      check("rd_nwrt", mem_nwrt, 1);
      check("rd_ra", mem_ra, 11'h123);
      check("rd_ca", mem_ca, 4'h4);
      @(negedge clk);
      #1;
      check("rd_idle_nce_nwrt", {mem_nce, mem_nwrt}, 2'b11);
      repeat (3) @(negedge clk);

      // Write from port 1 then read back from port 0
      req1 = 1'b1; we1 = 1'b1; addr1 = 15'd5; wdata1 = 64'hDEADBEEF;
      #1;
      check("wr_gnt1", gnt1, 1);
      @(negedge clk);
      req1 = 1'b0;
      req0 = 1'b1; we0 = 1'b0; addr0 = 15'd5;
      #1;
      check("wr_nwrt", mem_nwrt, 0);
      check("wr_din", mem_din, 64'hDEADBEEF);
      check("wr_ca", mem_ca, 4'h5);
      check("rb_gnt0", gnt0, 1);
      push_exp(1'b0, 64'hDEADBEEF);
      @(negedge clk);
      req0 = 1'b0;
      #1;
      check("rb_nce_nwrt", {mem_nce, mem_nwrt}, 2'b01);
      repeat (4) @(negedge clk);

      // Reset one cycle after a locked read acceptance
      req0 = 1'b1; lock0 = 1'b1; we0 = 1'b0; addr0 = 15'h0040; wdata0 = 64'h1111;
      #1;
      check("rr_gnt0", gnt0, 1);
      @(negedge clk);
      req0 = 1'b0; lock0 = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      req1 = 1'b1;
      #1;
      check("rr_gnt_gated", {gnt1, gnt0}, 0);
      check("rr_rvalid", {rvalid1, rvalid0}, 0);
      check("rr_rdata", rdata, 0);
      check("rr_nce_nwrt", {mem_nce, mem_nwrt}, 2'b11);
      check("rr_ra_ca", {mem_ra, mem_ca}, 0);
      check("rr_din", mem_din, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      #1;
      check("rr_idle_gnt", {gnt1, gnt0}, 2'b10);
      @(negedge clk);
      req1 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("rr_no_rvalid", {rvalid1, rvalid0}, 0);
         @(negedge clk);
      end

      // Both ports requesting without lock
      pulse_reset();
      req0 = 1'b1; we0 = 1'b1; addr0 = 15'h0100;
      req1 = 1'b1; we1 = 1'b1; addr1 = 15'h0200;
      for (int i = 0; i < 4; i++) begin
         #1;
`ifdef MEM_ARB_RR_EN
         check("tie_alternate", {gnt1, gnt0}, (i % 2 == 0) ? 2'b01 : 2'b10);
`else
         check("tie_port0", {gnt1, gnt0}, 2'b01);
`endif
         @(negedge clk);
      end
      req0 = 1'b0; req1 = 1'b0;

      // Locked burst from port 0 against a continuous port 1
      pulse_reset();
      req0 = 1'b1; lock0 = 1'b1; we0 = 1'b1; addr0 = 15'h0300;
      req1 = 1'b1; lock1 = 1'b0; we1 = 1'b1; addr1 = 15'h0400;
      for (int i = 0; i < 12; i++) begin
         #1;
         check("burst_gnt", {gnt1, gnt0}, (i == 8) ? 2'b10 : 2'b01);
         @(negedge clk);
      end
      req0 = 1'b0; lock0 = 1'b0; req1 = 1'b0;
      repeat (4) @(negedge clk);

      check("sb_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/jpeg_mem_arbiter.md
JPEG_MEM_ARBITER -- requirements
Module: jpeg_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 15, shall set the requester address width.
REQ-002 Parameter DATA_W, default 64, shall set the data width (eight 8-bit pixels).
REQ-003 Parameter BURST_MAX, default 8, shall set the maximum consecutive locked grants to one owner.
REQ-004 Port clk, input, 1, shall be the single clock; all state is updated on its rising edge.
REQ-005 Port reset, input, 1, shall be the asynchronous, active-low reset.
REQ-006 Ports req0/req1, input, 1 each, shall be the access requests.
REQ-007 Ports we0/we1, input, 1 each, shall select write (1) or read (0).
REQ-008 Ports lock0/lock1, input, 1 each, shall request burst ownership.
REQ-009 Ports addr0/addr1, input, ADDR_W each, shall carry the word address.
REQ-010 Ports wdata0/wdata1, input, DATA_W each, shall carry the write data.
REQ-011 Ports gnt0/gnt1, output, 1 each, shall give combinational grant; acceptance = req & gnt at a rising edge.
REQ-012 Ports rvalid0/rvalid1, output, 1 each, shall be one-cycle read-return strobes.
REQ-013 Port rdata, output, DATA_W, shall be the shared read-return data.
REQ-014 Ports mem_nce and mem_nwrt, output, 1 each, shall be the active-low SRAM chip enable and write enable.
REQ-015 Ports mem_ra, output, 11, and mem_ca, output, 4, shall be the SRAM row and column address (addr[14:4], addr[3:0]).
REQ-016 Port mem_din, output, DATA_W, shall be the SRAM write data; port mem_do, input, DATA_W, shall be the SRAM read data.

Function
REQ-017 At most one of gnt0/gnt1 shall be high in any cycle; gnt shall be 0 for a port whose req is 0.
REQ-018 An accepted command shall be registered onto the mem_* outputs at the acceptance edge, with mem_nce=0 and mem_nwrt=~we for one cycle.
REQ-019 With no acceptance, mem_nce=1 and mem_nwrt=1 shall hold the next cycle.
REQ-020 A read accepted at edge N shall raise the matching rvalid for exactly one cycle after edge N+2, with rdata = mem_do captured at edge N+2.
REQ-021 A write shall produce no rvalid; throughput shall be one access per cycle, served in acceptance order.
REQ-022 The FSM shall have states IDLE, OWN0 and OWN1; IDLE shall arbitrate freely and OWNx shall force gnt of the other port to 0.
REQ-023 IDLE shall move to OWNx when port x is accepted with lockx=1.
REQ-024 OWNx shall return to IDLE when reqx=0, lockx=0, or the burst counter reaches BURST_MAX accepted beats; on exit the other port shall have priority for one decision.
REQ-025 The burst counter shall reset to 0 on entry to IDLE and shall not wrap.
REQ-026 When only one port requests in IDLE, that port shall be granted.

Reset
REQ-027 Asserting reset shall force IDLE, counter 0, gnt0/gnt1=0, rvalid0/rvalid1=0, rdata=0, mem_nce=1, mem_nwrt=1, and mem_ra, mem_ca and mem_din=0.
REQ-028 Reads in flight at reset shall be discarded, with no rvalid after release.

Configuration
REQ-029 With MEM_ARB_RR_EN defined, ties in IDLE shall go to the port not granted most recently (port 0 first after reset).
REQ-030 With MEM_ARB_RR_EN undefined, ties shall always go to port 0, and the lock and burst rules shall be unchanged.

Structure
REQ-031 Package jpeg_mem_pkg shall hold ADDR_W, DATA_W, RA_W=11, CA_W=4 and the FSM state type.
REQ-032 No sub-module is needed; the grant logic, FSM and read-return pipeline shall be in one module.

Verification
REQ-033 req0 read of addr 0x1234 with the SRAM holding 0xA5: expect mem_ra=0x123, mem_ca=0x4, mem_nce=0 one cycle, rvalid0 two cycles after acceptance with rdata=0xA5.
REQ-034 req0 and req1 held continuously, no lock, MEM_ARB_RR_EN defined: expect grants alternating 0,1,0,1; with the macro undefined, expect gnt0 every cycle.
REQ-035 lock0=1 and req0 held for 12 cycles with req1 held: expect 8 consecutive gnt0, then gnt1, then gnt0 again.
REQ-036 Write 0xDEADBEEF to addr 5 from port 1, then read addr 5 from port 0 on the next cycle: expect rvalid0 with rdata=0xDEADBEEF and no rvalid1.
REQ-037 reset asserted one cycle after a read acceptance: expect no rvalid, all outputs at reset values, and IDLE after release.
